// File: rtl/hog_svm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hog_svm_pkg
//  Description : Shared constants, FSM state type and weight-row type for the
//                HOG/SVM window accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package hog_svm_pkg;

    localparam int c_BIN_W   = 32;            // unsigned histogram bin width
    localparam int c_DATA_W  = 9 * c_BIN_W;   // one cell = 9 bins
    localparam int c_W_W     = 16;            // signed SVM weight width
    localparam int c_N_BLK   = 105;           // blocks per detection window
    localparam int c_ACC_W   = 64;            // accumulator / score width
    localparam int c_BID_W   = 13;            // block index port width
    localparam int c_WADDR_W = 7;             // weight row address width
    localparam int c_N_TERMS = 36;            // 4 cells x 9 bins per block

    // Sequencer states: waiting for bid 0, or walking through a window.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } svm_state_e;

    // One weight row: element k at bits [k*c_W_W +: c_W_W].
    typedef logic [c_N_TERMS*c_W_W-1:0] weight_row_t;

endpackage
`default_nettype wire

// File: rtl/svm_window_accum_if.sv
`default_nettype none
// ============================================================================
//  Module      : svm_window_accum_if
//  Description : Block-feature stream, weight-write port, bias and score
//                outputs of the SVM window accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface svm_window_accum_if
    import hog_svm_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int W_W    = c_W_W,
    parameter int ACC_W  = c_ACC_W
);

    logic                         i_valid;
    logic [c_BID_W-1:0]           bid;
    logic [DATA_W-1:0]            fea_a;
    logic [DATA_W-1:0]            fea_b;
    logic [DATA_W-1:0]            fea_c;
    logic [DATA_W-1:0]            fea_d;
    logic                         w_we;
    logic [c_WADDR_W-1:0]         w_addr;
    logic [c_N_TERMS*W_W-1:0]     w_data;
    logic signed [ACC_W-1:0]      bias;
    logic                         o_valid;
    logic signed [ACC_W-1:0]      o_score;
    logic                         o_det;
    logic                         o_err;

    modport master (
        output i_valid, bid, fea_a, fea_b, fea_c, fea_d,
        output w_we, w_addr, w_data, bias,
        input  o_valid, o_score, o_det, o_err
    );

    modport slave (
        input  i_valid, bid, fea_a, fea_b, fea_c, fea_d,
        input  w_we, w_addr, w_data, bias,
        output o_valid, o_score, o_det, o_err
    );

endinterface
`default_nettype wire

// File: rtl/svm_dot36.sv
`default_nettype none
// ============================================================================
//  Module      : svm_dot36
//  Description : 36-term dot product of unsigned bins and signed weights.
//                Stage A registers the 36 products, stage B registers their
//                sum sign-extended to ACC_W. first/last tags ride along.
//  Revision    : 1.0 - initial release
// ============================================================================
module svm_dot36
    import hog_svm_pkg::*;
#(
    parameter int BIN_W = c_BIN_W,
    parameter int W_W   = c_W_W,
    parameter int ACC_W = c_ACC_W
)(
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          i_valid,
    input  wire logic                          i_first,
    input  wire logic                          i_last,
    input  wire logic [c_N_TERMS*BIN_W-1:0]    i_bins,
    input  wire logic [c_N_TERMS*W_W-1:0]      i_wrow,
    output logic                               o_valid,
    output logic                               o_first,
    output logic                               o_last,
    output logic signed [ACC_W-1:0]            o_dot
);

    // Zero-extended bin times signed weight needs one extra bit; 36 terms
    // need six more bits of headroom for the sum.
    localparam int c_PROD_W = BIN_W + W_W + 1;
    localparam int c_SUM_W  = c_PROD_W + 6;

    logic signed [c_PROD_W-1:0] w_prod [c_N_TERMS];
    logic signed [c_PROD_W-1:0] r_prod [c_N_TERMS];
    logic signed [c_SUM_W-1:0]  w_sum;
    logic                       r_p_valid, r_p_first, r_p_last;
    logic                       r_d_valid, r_d_first, r_d_last;
    logic signed [ACC_W-1:0]    r_dot;

    for (genvar k = 0; k < c_N_TERMS; k++) begin : g_mul
        logic signed [c_PROD_W-1:0] w_bin_ext;
        logic signed [c_PROD_W-1:0] w_wgt_ext;
        assign w_bin_ext = $signed({{(W_W+1){1'b0}}, i_bins[k*BIN_W +: BIN_W]});
        assign w_wgt_ext = $signed({{(BIN_W+1){i_wrow[k*W_W+W_W-1]}}, i_wrow[k*W_W +: W_W]});
        assign w_prod[k] = w_bin_ext * w_wgt_ext;
    end

    // Product register (datapath only, no reset needed).
    always_ff @(posedge clk) begin
        r_prod <= w_prod;
    end

    // Adder tree over the registered products.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < c_N_TERMS; k++) begin
            w_sum = w_sum + c_SUM_W'(r_prod[k]);
        end
    end

    // Dot register, sign-extended to the accumulator width.
    always_ff @(posedge clk) begin
        r_dot <= ACC_W'(w_sum);
    end

    // Valid and tag pipeline through both stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_valid <= 1'b0;
            r_p_first <= 1'b0;
            r_p_last  <= 1'b0;
            r_d_valid <= 1'b0;
            r_d_first <= 1'b0;
            r_d_last  <= 1'b0;
        end else begin
            r_p_valid <= i_valid;
            r_p_first <= i_first;
            r_p_last  <= i_last;
            r_d_valid <= r_p_valid;
            r_d_first <= r_p_first;
            r_d_last  <= r_p_last;
        end
    end

    assign o_valid = r_d_valid;
    assign o_first = r_d_first;
    assign o_last  = r_d_last;
    assign o_dot   = r_dot;

endmodule
`default_nettype wire

// File: rtl/svm_window_accum.sv
`default_nettype none
// ============================================================================
//  Module      : svm_window_accum
//  Description : Accumulates per-block SVM dot products over one detection
//                window and emits score = sum + bias with a detection flag.
//                Sequencer checks block order and flags sequencing errors.
//                Optional macro SVM_SCORE_SAT_EN: saturate accumulator and
//                bias addition instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module svm_window_accum
    import hog_svm_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int BIN_W  = c_BIN_W,
    parameter int W_W    = c_W_W,
    parameter int N_BLK  = c_N_BLK,
    parameter int ACC_W  = c_ACC_W
)(
    input  wire logic          clk,
    input  wire logic          rst,
    svm_window_accum_if.slave  bus
);

    localparam logic [c_BID_W-1:0]   c_LAST_BID  = c_BID_W'(N_BLK - 1);
    localparam logic [c_BID_W-1:0]   c_NBLK_BID  = c_BID_W'(N_BLK);
    localparam logic [c_WADDR_W-1:0] c_NBLK_ADDR = c_WADDR_W'(N_BLK);

`ifdef SVM_SCORE_SAT_EN
    localparam logic signed [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    // Signed add used for both the accumulator and the bias; wraps unless
    // saturation is compiled in.
    function automatic logic signed [ACC_W-1:0] acc_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
`ifdef SVM_SCORE_SAT_EN
        if (s[ACC_W] != s[ACC_W-1]) begin
            return s[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
        end
`endif
        return s[ACC_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    svm_state_e         r_state, w_state_nxt;
    logic [c_BID_W-1:0] r_exp_bid, w_exp_bid_nxt;
    logic               w_accept, w_first, w_last, w_err;

    // State and expected-bid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_exp_bid <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_exp_bid <= w_exp_bid_nxt;
        end
    end

    // Next state, accept decision, first/last tags and error pulse.
    always_comb begin
        w_state_nxt   = r_state;
        w_exp_bid_nxt = r_exp_bid;
        w_accept      = 1'b0;
        w_first       = 1'b0;
        w_last        = 1'b0;
        w_err         = 1'b0;
        if (bus.i_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.bid == '0) begin
                        w_accept = 1'b1;
                        w_first  = 1'b1;
                        if (N_BLK == 1) begin
                            w_last = 1'b1;
                        end else begin
                            w_state_nxt   = ST_ACCUM;
                            w_exp_bid_nxt = c_BID_W'(1);
                        end
                    end else begin
                        w_err = 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (bus.bid == r_exp_bid) begin
                        w_accept = 1'b1;
                        if (bus.bid == c_LAST_BID) begin
                            w_last      = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_exp_bid_nxt = r_exp_bid + c_BID_W'(1);
                        end
                    end else if (bus.bid == '0) begin
                        // Restart: the partial window never sees a last tag,
                        // and this first-tagged block reloads the accumulator.
                        w_accept      = 1'b1;
                        w_first       = 1'b1;
                        w_err         = 1'b1;
                        w_exp_bid_nxt = c_BID_W'(1);
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: feature capture and synchronous weight-row read
    // ------------------------------------------------------------------
    weight_row_t                  r_wmem [N_BLK];
    weight_row_t                  r1_wrow;
    logic [c_N_TERMS*BIN_W-1:0]   r1_bins;
    logic [c_WADDR_W-1:0]         w_rd_idx;
    logic                         r1_valid, r1_first, r1_last, r_err;

    // Out-of-range bids are dropped anyway; read row 0 to stay in bounds.
    assign w_rd_idx = (bus.bid < c_NBLK_BID) ? bus.bid[c_WADDR_W-1:0] : '0;

    // Weight memory (kept through reset); read returns the pre-write row.
    always_ff @(posedge clk) begin
        if (bus.w_we && (bus.w_addr < c_NBLK_ADDR)) begin
            r_wmem[bus.w_addr] <= bus.w_data;
        end
        r1_wrow <= r_wmem[w_rd_idx];
        r1_bins <= {bus.fea_d, bus.fea_c, bus.fea_b, bus.fea_a};
    end

    // Stage-1 valid/tags and the error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_first <= 1'b0;
            r1_last  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r1_valid <= w_accept;
            r1_first <= w_first;
            r1_last  <= w_last;
            r_err    <= w_err;
        end
    end

    // ------------------------------------------------------------------
    // Stages 2-3: products and dot
    // ------------------------------------------------------------------
    logic                    w_d_valid, w_d_first, w_d_last;
    logic signed [ACC_W-1:0] w_dot;

    svm_dot36 #(
        .BIN_W (BIN_W),
        .W_W   (W_W),
        .ACC_W (ACC_W)
    ) u_dot (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r1_valid),
        .i_first (r1_first),
        .i_last  (r1_last),
        .i_bins  (r1_bins),
        .i_wrow  (r1_wrow),
        .o_valid (w_d_valid),
        .o_first (w_d_first),
        .o_last  (w_d_last),
        .o_dot   (w_dot)
    );

    // ------------------------------------------------------------------
    // Stage 4: accumulator; Stage 5: score output
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] r_acc;
    logic                    r4_fire;
    logic signed [ACC_W-1:0] w_score;
    logic                    r_o_valid, r_o_det;
    logic signed [ACC_W-1:0] r_o_score;

    // First-tagged entries load, others add, so windows can abut.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r4_fire <= 1'b0;
        end else begin
            r4_fire <= w_d_valid & w_d_last;
            if (w_d_valid) begin
                r_acc <= w_d_first ? w_dot : acc_add(r_acc, w_dot);
            end
        end
    end

    assign w_score = acc_add(r_acc, bus.bias);

    // Score register; holds its value between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_valid <= 1'b0;
            r_o_score <= '0;
            r_o_det   <= 1'b0;
        end else begin
            r_o_valid <= r4_fire;
            if (r4_fire) begin
                r_o_score <= w_score;
                r_o_det   <= ~w_score[ACC_W-1] & (|w_score);
            end
        end
    end

    assign bus.o_valid = r_o_valid;
    assign bus.o_score = r_o_score;
    assign bus.o_det   = r_o_det;
    assign bus.o_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_svm_window_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_svm_window_accum
//  Description : Self-checking bench for svm_window_accum against a window-
//                level arithmetic model of the SVM score.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_svm_window_accum;
    import hog_svm_pkg::*;

    localparam int NB = c_N_BLK;

    typedef struct {
        int     cyc;
        longint score;
        bit     det;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    svm_window_accum_if bus ();

    svm_window_accum dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int                 cyc = 0;
    int                 n_cmp = 0;
    int                 n_bad = 0;
    int                 wm [NB][36];
    bit                 rand_bins;
    logic [31:0]        bin_fill;
    logic signed [15:0] wval;
    longint             bias_m;
    int                 last_drive;
    int                 win_start;
    ev_t                vq [$];
    int                 eq [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every score pulse and error pulse with its cycle number.
    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) vq.push_back('{cyc, bus.o_score, bus.o_det});
        if (bus.o_err === 1'b1) eq.push_back(cyc);
    end

    // Signed add as the window score rules define it.
    function automatic longint madd(input longint a, input longint b);
        longint s;
        s = a + b;
`ifdef SVM_SCORE_SAT_EN
        if (a >= 0 && b >= 0 && s < 0) return 64'sh7FFF_FFFF_FFFF_FFFF;
        if (a < 0 && b < 0 && s >= 0) return 64'sh8000_0000_0000_0000;
`endif
        return s;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            bus.w_we    = 1'b0;
        end
    endtask

    task automatic write_row(input int a, input bit rnd);
        logic [36*16-1:0]   row;
        logic signed [15:0] ws;
        for (int k = 0; k < 36; k++) begin
            ws = rnd ? 16'($urandom) : wval;
            row[k*16 +: 16] = ws;
            if (a < NB) wm[a][k] = ws;
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.w_we    = 1'b1;
        bus.w_addr  = 7'(a);
        bus.w_data  = row;
    endtask

    task automatic load_weights(input bit rnd);
        for (int a = 0; a < NB; a++) write_row(a, rnd);
        idle(1);
    endtask

    task automatic send_bid(input int b, output longint dot);
        logic [4*c_DATA_W-1:0] f;
        logic [31:0]           v;
        dot = 0;
        for (int k = 0; k < 36; k++) begin
            v = rand_bins ? $urandom : bin_fill;
            f[k*32 +: 32] = v;
            if (b < NB) dot += longint'({32'd0, v}) * longint'(wm[b][k]);
        end
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.bid     = 13'(b);
        bus.fea_a   = f[0*c_DATA_W +: c_DATA_W];
        bus.fea_b   = f[1*c_DATA_W +: c_DATA_W];
        bus.fea_c   = f[2*c_DATA_W +: c_DATA_W];
        bus.fea_d   = f[3*c_DATA_W +: c_DATA_W];
        bus.w_we    = 1'b0;
        last_drive  = cyc;
    endtask

    task automatic send_range(input int lo, input int hi);
        longint d;
        for (int b = lo; b <= hi; b++) send_bid(b, d);
    endtask

    // Full window 0..NB-1; optionally rewrite row wr_bid in the same cycle it
    // is read (that block must still use the old row).
    task automatic run_window(input int wr_bid, output longint exp_score);
        longint             acc, d;
        logic [36*16-1:0]   row;
        logic signed [15:0] ws;
        acc = 0;
        for (int b = 0; b < NB; b++) begin
            send_bid(b, d);
            if (b == 0) win_start = last_drive;
            acc = (b == 0) ? d : madd(acc, d);
            if (b == wr_bid) begin
                for (int k = 0; k < 36; k++) begin
                    ws = 16'($urandom);
                    row[k*16 +: 16] = ws;
                    wm[b][k] = ws;
                end
                bus.w_we   = 1'b1;
                bus.w_addr = 7'(b);
                bus.w_data = row;
            end
        end
        exp_score = madd(acc, bias_m);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.bid = '0; bus.w_we = 1'b0; bus.w_addr = '0;
        bus.w_data = '0; bus.bias = '0;
        bus.fea_a = '0; bus.fea_b = '0; bus.fea_c = '0; bus.fea_d = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.o_valid); end
        n_cmp++; if (bus.o_score !== '0) begin n_bad++; $display("FAIL rst_score: got %0d want 0", bus.o_score); end
        n_cmp++; if (bus.o_det !== 1'b0) begin n_bad++; $display("FAIL rst_det: got %b want 0", bus.o_det); end
        n_cmp++; if (bus.o_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", bus.o_err); end
        rst = 1'b0;
        idle(2);
        n_cmp++; if (bus.o_valid !== 1'b0 || bus.o_err !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle: got v=%b e=%b want 0/0", bus.o_valid, bus.o_err); end
    endtask

    task automatic test_all_ones();
        longint e;
        int     ld;
        wval = 16'sd1; load_weights(1'b0);
        rand_bins = 1'b0; bin_fill = 32'd1; bias_m = 0; bus.bias = 0;
        vq.delete(); eq.delete();
        run_window(-1, e); ld = last_drive; idle(10);
        n_cmp++; if (vq.size() != 1) begin n_bad++; $display("FAIL ones_count: got %0d want 1", vq.size()); end
        if (vq.size() > 0) begin
            n_cmp++; if (vq[0].cyc != ld + 5) begin n_bad++; $display("FAIL ones_latency: got cycle %0d want %0d", vq[0].cyc, ld + 5); end
            n_cmp++; if (vq[0].score != 3780) begin n_bad++; $display("FAIL ones_score: got %0d want 3780", vq[0].score); end
            n_cmp++; if (vq[0].det != 1'b1) begin n_bad++; $display("FAIL ones_det: got %b want 1", vq[0].det); end
        end
        n_cmp++; if (eq.size() != 0) begin n_bad++; $display("FAIL ones_err: got %0d pulses want 0", eq.size()); end
    endtask

    task automatic test_negative();
        longint e;
        wval = -16'sd1; load_weights(1'b0);
        rand_bins = 1'b0; bin_fill = 32'd2; bias_m = 100; bus.bias = 100;
        vq.delete(); eq.delete();
        run_window(-1, e); idle(10);
        n_cmp++; if (vq.size() != 1) begin n_bad++; $display("FAIL neg_count: got %0d want 1", vq.size()); end
        if (vq.size() > 0) begin
            n_cmp++; if (vq[0].score != -7460) begin n_bad++; $display("FAIL neg_score: got %0d want -7460", vq[0].score); end
            n_cmp++; if (vq[0].det != 1'b0) begin n_bad++; $display("FAIL neg_det: got %b want 0", vq[0].det); end
        end
    endtask

    task automatic test_back_to_back();
        longint e1, e2;
        int     ld1;
        load_weights(1'b1);
        rand_bins = 1'b1;
        bias_m = longint'($signed($urandom)); bus.bias = bias_m;
        vq.delete(); eq.delete();
        run_window(-1, e1); ld1 = last_drive;
        run_window(-1, e2); idle(10);
        n_cmp++; if (vq.size() != 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", vq.size()); end
        if (vq.size() == 2) begin
            n_cmp++; if (vq[0].cyc != ld1 + 5) begin n_bad++; $display("FAIL b2b_latency: got cycle %0d want %0d", vq[0].cyc, ld1 + 5); end
            n_cmp++; if (vq[1].cyc - vq[0].cyc != NB) begin n_bad++; $display("FAIL b2b_spacing: got %0d want %0d", vq[1].cyc - vq[0].cyc, NB); end
            n_cmp++; if (vq[0].score != e1) begin n_bad++; $display("FAIL b2b_score0: got %0d want %0d", vq[0].score, e1); end
            n_cmp++; if (vq[1].score != e2) begin n_bad++; $display("FAIL b2b_score1: got %0d want %0d", vq[1].score, e2); end
            n_cmp++; if (vq[1].det != (e2 > 0)) begin n_bad++; $display("FAIL b2b_det1: got %b want %b", vq[1].det, (e2 > 0)); end
        end
    endtask

    task automatic test_restart();
        longint e;
        vq.delete(); eq.delete();
        send_range(0, 9);
        run_window(-1, e); idle(10);
        n_cmp++; if (eq.size() != 1) begin n_bad++; $display("FAIL restart_errcount: got %0d want 1", eq.size()); end
        if (eq.size() > 0) begin
            n_cmp++; if (eq[0] != win_start + 1) begin n_bad++; $display("FAIL restart_errcycle: got %0d want %0d", eq[0], win_start + 1); end
        end
        n_cmp++; if (vq.size() != 1) begin n_bad++; $display("FAIL restart_count: got %0d want 1", vq.size()); end
        if (vq.size() > 0) begin
            n_cmp++; if (vq[0].score != e) begin n_bad++; $display("FAIL restart_score: got %0d want %0d", vq[0].score, e); end
        end
    endtask

    task automatic test_abort();
        longint e, d;
        int     ab, i7, i200;
        vq.delete(); eq.delete();
        send_range(0, 9); send_bid(11, d); ab = last_drive; idle(10);
        n_cmp++; if (eq.size() != 1) begin n_bad++; $display("FAIL abort_errcount: got %0d want 1", eq.size()); end
        if (eq.size() > 0) begin
            n_cmp++; if (eq[0] != ab + 1) begin n_bad++; $display("FAIL abort_errcycle: got %0d want %0d", eq[0], ab + 1); end
        end
        n_cmp++; if (vq.size() != 0) begin n_bad++; $display("FAIL abort_novalid: got %0d want 0", vq.size()); end
        // Idle rejects a non-zero bid; an out-of-range bid aborts a window;
        // a following window from bid 0 is then accepted cleanly.
        eq.delete();
        send_bid(7, d); i7 = last_drive;
        send_range(0, 3); send_bid(200, d); i200 = last_drive;
        run_window(-1, e); idle(10);
        n_cmp++; if (eq.size() != 2) begin n_bad++; $display("FAIL abort2_errcount: got %0d want 2", eq.size()); end
        if (eq.size() == 2) begin
            n_cmp++; if (eq[0] != i7 + 1 || eq[1] != i200 + 1) begin n_bad++; $display("FAIL abort2_errcycles: got %0d,%0d want %0d,%0d", eq[0], eq[1], i7 + 1, i200 + 1); end
        end
        n_cmp++; if (vq.size() != 1) begin n_bad++; $display("FAIL abort2_count: got %0d want 1", vq.size()); end
        if (vq.size() > 0) begin
            n_cmp++; if (vq[0].score != e) begin n_bad++; $display("FAIL abort2_score: got %0d want %0d", vq[0].score, e); end
        end
    endtask

    task automatic test_reset_in_flight();
        longint e;
        vq.delete(); eq.delete();
        run_window(-1, e);
        @(negedge clk); bus.i_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        idle(10);
        n_cmp++; if (vq.size() != 0) begin n_bad++; $display("FAIL rstfly_novalid: got %0d want 0", vq.size()); end
        n_cmp++; if (bus.o_score !== '0) begin n_bad++; $display("FAIL rstfly_score: got %0d want 0", bus.o_score); end
        run_window(-1, e); idle(10);
        n_cmp++; if (vq.size() != 1) begin n_bad++; $display("FAIL rstfly_count: got %0d want 1", vq.size()); end
        if (vq.size() > 0) begin
            n_cmp++; if (vq[0].score != e) begin n_bad++; $display("FAIL rstfly_weights: got %0d want %0d", vq[0].score, e); end
        end
    endtask

    task automatic test_read_during_write();
        longint e1, e2;
        write_row(120, 1'b1); idle(1);
        vq.delete(); eq.delete();
        run_window(5, e1);
        run_window(-1, e2); idle(10);
        n_cmp++; if (vq.size() != 2) begin n_bad++; $display("FAIL rdw_count: got %0d want 2", vq.size()); end
        if (vq.size() == 2) begin
            n_cmp++; if (vq[0].score != e1) begin n_bad++; $display("FAIL rdw_old_row: got %0d want %0d", vq[0].score, e1); end
            n_cmp++; if (vq[1].score != e2) begin n_bad++; $display("FAIL rdw_new_row: got %0d want %0d", vq[1].score, e2); end
        end
    endtask

    task automatic test_saturation();
        longint e;
        wval = 16'sh7FFF; load_weights(1'b0);
        rand_bins = 1'b0; bin_fill = 32'hFFFF_FFFF;
        bias_m = 64'sh7FFF_FFFF_FFFF_FFFF; bus.bias = bias_m;
        vq.delete(); eq.delete();
        run_window(-1, e); idle(10);
        n_cmp++; if (vq.size() != 1) begin n_bad++; $display("FAIL sat_count: got %0d want 1", vq.size()); end
        if (vq.size() > 0) begin
            n_cmp++; if (vq[0].score != e) begin n_bad++; $display("FAIL sat_score: got %0d want %0d", vq[0].score, e); end
            n_cmp++; if (vq[0].det != (e > 0)) begin n_bad++; $display("FAIL sat_det: got %b want %b", vq[0].det, (e > 0)); end
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_negative();
        test_back_to_back();
        test_restart();
        test_abort();
        test_reset_in_flight();
        test_read_during_write();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/svm_window_accum.md
SVM_WINDOW_ACCUM -- requirements
Module: svm_window_accum

Interface
REQ-001 SHALL have parameter DATA_W, default 288, width of one cell feature vector (9 bins x BIN_W).
REQ-002 SHALL have parameter BIN_W, default 32, unsigned width of one bin value.
REQ-003 SHALL have parameter W_W, default 16, signed width of one SVM weight.
REQ-004 SHALL have parameter N_BLK, default 105, number of blocks per detection window.
REQ-005 SHALL have parameter ACC_W, default 64, signed accumulator and score width.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port i_valid  input  1  block features valid this cycle (upstream o_valid).
REQ-009 SHALL have port bid  input  13  block index within window, 0..N_BLK-1.
REQ-010 SHALL have ports fea_a, fea_b, fea_c, fea_d  input  DATA_W each  four cell histograms of one block.
REQ-011 SHALL have port w_we  input  1  weight row write enable.
REQ-012 SHALL have port w_addr  input  7  weight row index (block index).
REQ-013 SHALL have port w_data  input  36*W_W  one weight row, element k at bits [k*W_W +: W_W]; k=0..8 fea_a bins, 9..17 fea_b, 18..26 fea_c, 27..35 fea_d.
REQ-014 SHALL have port bias  input  ACC_W  signed SVM bias, sampled when the score is formed.
REQ-015 SHALL have port o_valid  output  1  one-cycle pulse, window score valid.
REQ-016 SHALL have port o_score  output  ACC_W  signed window score (sum of dot products + bias).
REQ-017 SHALL have port o_det  output  1  detection flag, o_score > 0 (strict, signed).
REQ-018 SHALL have port o_err  output  1  one-cycle pulse on a block sequencing error.

Function
REQ-019 SHALL accept a block every cycle i_valid=1; no backpressure exists.
REQ-020 SHALL compute per block dot = sum over k=0..35 of feature_k (unsigned, zero-extended) x weight_k (signed), full precision, sign-extended to ACC_W.
REQ-021 SHALL pipeline: T+1 register features and synchronous weight row read at bid; T+2 register 36 products; T+3 register dot; T+4 update accumulator; T+5 o_valid with o_score = acc + bias.
REQ-022 SHALL run FSM IDLE (expect bid 0) / ACCUM (expect bid = previous+1); each pipeline entry carries first/last tags.
REQ-023 SHALL, in IDLE, on bid=0 tag first, enter ACCUM (or stay IDLE with first+last if N_BLK=1); on bid!=0 drop the block and pulse o_err at T+1.
REQ-024 SHALL, in ACCUM, on expected bid accept it; on bid=N_BLK-1 tag last and return to IDLE.
REQ-025 SHALL, in ACCUM, on bid=0 discard the partial window, restart with this block tagged first, pulse o_err at T+1.
REQ-026 SHALL, in ACCUM, on any other unexpected bid (including bid>=N_BLK) drop it, discard the partial window (no o_valid for it), go IDLE, pulse o_err at T+1.
REQ-027 SHALL load (not add) the accumulator on a first-tagged entry, so back-to-back windows need zero idle cycles.
REQ-028 SHALL, on w_we with w_addr equal to the row being read in the same cycle, return the old row; writes are permitted at any time.
REQ-029 SHALL ignore w_we when w_addr >= N_BLK.

Reset
REQ-030 SHALL, on rst, clear FSM to IDLE, all pipeline valid bits/tags, accumulator, o_valid=0, o_score=0, o_det=0, o_err=0.
REQ-031 SHALL preserve weight memory contents across rst; a window in flight at rst produces no o_valid.

Configuration
REQ-032 SHALL honour macro SVM_SCORE_SAT_EN: defined -> accumulator update and bias addition saturate to signed ACC_W min/max; undefined -> both wrap modulo 2^ACC_W.

Structure
REQ-033 SHALL take DATA_W, BIN_W, W_W, N_BLK, ACC_W defaults, the FSM state enum and the weight-row typedef from shared package hog_svm_pkg.
REQ-034 SHALL place the 36-way multiply and adder tree (T+2..T+3) in sub-module svm_dot36.

Verification
REQ-035 SHALL cover: all weights 1, every bin 1, bias 0, bids 0..104 -> one o_valid 5 cycles after bid 104, o_score=3780, o_det=1.
REQ-036 SHALL cover: all weights -1, bins 2, bias 100, full window -> o_score=-7460, o_det=0.
REQ-037 SHALL cover: two windows back-to-back, no gaps -> two o_valid pulses exactly 105 cycles apart, each independently correct.
REQ-038 SHALL cover: bids 0..9 then 0..104 -> o_err pulse once, single o_valid with full-window score only.
REQ-039 SHALL cover: bids 0..9 then bid 11 -> o_err pulse, FSM IDLE, no o_valid; rst asserted mid-window -> no o_valid, weights intact.
REQ-040 SHALL cover: weights 0x7FFF, bins 0xFFFFFFFF, bias max -> saturated max score with SVM_SCORE_SAT_EN, wrapped value without.
